// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and I2C-master signal bundle for i2c_cmd_arbiter.
// slave = arbiter side, master = requester/I2C-master side.
interface i2c_cmd_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_cmd;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                err;
  logic [1:0]          err_code;
  logic [31:0]         control_reg;
  logic                i2c_busy;
  logic                i2c_ack_error;
  logic                arb_busy;

  modport slave (
    input  req,
    input  req_cmd,
    input  i2c_busy,
    input  i2c_ack_error,
    output gnt,
    output done,
    output err,
    output err_code,
    output control_reg,
    output arb_busy
  );

  modport master (
    output req,
    output req_cmd,
    output i2c_busy,
    output i2c_ack_error,
    input  gnt,
    input  done,
    input  err,
    input  err_code,
    input  control_reg,
    input  arb_busy
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C master between N requesters.
// Launches each latched command with a clean 0->1 edge on bit 17.
module i2c_cmd_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_WAIT    = 2048,
  parameter int XFER_TIMEOUT = 2000000,
  parameter int PTR_W        = 2
) (
  input  logic            clk,
  input  logic            reset,
  i2c_cmd_arbiter_if.slave bus
);

  localparam int CNT_MAX =
    (BUSY_WAIT > XFER_TIMEOUT) ? BUSY_WAIT : XFER_TIMEOUT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(BUSY_WAIT - 1);
  localparam logic [CNT_W-1:0] XT_LAST = CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  localparam logic [PTR_W:0]   NR      = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

  localparam int          START_BIT  = 17;
  localparam logic [31:0] START_MASK = 32'h0002_0000;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_NACK  = 2'b01;
  localparam logic [1:0] E_START = 2'b10;
  localparam logic [1:0] E_XFER  = 2'b11;

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [PTR_W-1:0] ptr;
  logic [31:0]      cmd_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             nack;
  logic [N_REQ-1:0] win_q;

  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             err_q;
  logic [1:0]       code_q;
  logic [31:0]      ctl_q;
  logic             abusy_q;

  logic             win_hit;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W:0]   pos;
  logic [N_REQ-1:0] win_oh;
  logic [31:0]      win_cmd;

  logic             fin;
  logic [1:0]       fin_code;

  // Rotating search: first set req strictly after the last winner.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    pos     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (pos >= NR) pos = pos - NR;
      if (!win_hit && bus.req[pos[PTR_W-1:0]]) begin
        win_hit = 1'b1;
        win_idx = pos[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_oh  = '0;
    win_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_oh[i] = win_hit;
        win_cmd   = bus.req_cmd[32*i +: 32];
      end
    end
  end

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n  = state;
    fin      = 1'b0;
    fin_code = E_OK;
    unique case (state)
      S_IDLE: begin
        if (|bus.req) state_n = S_GRANT;
      end
      S_GRANT: begin
        state_n = win_hit ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (bus.i2c_busy) begin
          state_n = S_RUN;
        end else if (cnt >= BW_LAST) begin
          fin      = 1'b1;
          fin_code = E_START;
        end
      end
      S_RUN: begin
        if (!bus.i2c_busy) begin
          fin      = 1'b1;
          fin_code = nack ? E_NACK : E_OK;
        end else if (cnt >= XT_LAST) begin
          fin      = 1'b1;
          fin_code = E_XFER;
        end
      end
      S_FINISH: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (fin) state_n = S_FINISH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= PTR_RST;
      cmd_r   <= '0;
      cnt     <= '0;
      nack    <= 1'b0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= E_OK;
      ctl_q   <= '0;
      abusy_q <= 1'b0;
    end else begin
      state  <= state_n;
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state)
        S_GRANT: begin
          if (win_hit) begin
            gnt_q   <= win_oh;
            win_q   <= win_oh;
            ptr     <= win_idx;
            cmd_r   <= win_cmd & ~START_MASK;
            ctl_q   <= win_cmd & ~START_MASK;
            abusy_q <= 1'b1;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          nack  <= 1'b0;
          ctl_q <= cmd_r | START_MASK;
        end
        S_LAUNCH: begin
          cnt <= bus.i2c_busy ? '0 : cnt_inc;
        end
        S_RUN: begin
          cnt <= cnt_inc;
          if (bus.i2c_ack_error) nack <= 1'b1;
        end
        S_FINISH: begin
          abusy_q <= 1'b0;
        end
        default: begin
        end
      endcase
      // Drop the start bit; the rest of the command word holds.
      if (fin) begin
        ctl_q[START_BIT] <= 1'b0;
        done_q           <= win_q;
        err_q            <= |fin_code;
        code_q           <= fin_code;
      end
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.err_code    = code_q;
  assign bus.control_reg = ctl_q;
  assign bus.arb_busy    = abusy_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a hand-driven I2C master.
// Expected values are fixed constants derived from the cycle timing.
module tb_i2c_cmd_arbiter;

  localparam logic [31:0] B17 = 32'h0002_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] cmds [4] = '{
    32'h0040_0105, 32'h0062_0203, 32'h0010_0301, 32'h0081_0407
  };

  i2c_cmd_arbiter_if #(.N_REQ(4)) bus ();

  i2c_cmd_arbiter #(
    .N_REQ(4),
    .BUSY_WAIT(16),
    .XFER_TIMEOUT(100),
    .PTR_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    bit found = 0;
    g = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.gnt != 0) begin
        found = 1;
        g = bus.gnt;
      end
    end
    check("gnt_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_done(output int n);
    bit found = 0;
    n = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      n++;
      if (bus.done != 0) found = 1;
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  // Called in the cycle gnt is visible; runs a transfer to done.
  task automatic do_xfer(input int w, input int nbusy,
                         input bit nack, input logic [1:0] code);
    int n;
    check("load_ctl", bus.control_reg, cmds[w] & ~B17);
    tick();
    check("launch_ctl", bus.control_reg, cmds[w] | B17);
    bus.i2c_busy = 1'b1;
    tick();
    for (int k = 0; k < nbusy; k++) begin
      bus.i2c_ack_error = nack && (k == 0);
      tick();
    end
    bus.i2c_ack_error = 1'b0;
    bus.i2c_busy = 1'b0;
    wait_done(n);
    check("done_mask", 32'(bus.done), 32'(1 << w));
    check("err", 32'(bus.err), 32'(code != 2'b00));
    check("err_code", 32'(bus.err_code), 32'(code));
    check("fin_ctl", bus.control_reg, cmds[w] & ~B17);
    tick();
    check("done_clr", 32'(bus.done), 32'd0);
    check("arb_idle", 32'(bus.arb_busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_code", 32'(bus.err_code), 32'd0);
    check("rst_ctl", bus.control_reg, 32'd0);
    check("rst_abusy", 32'(bus.arb_busy), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    int n;
    int order [6] = '{0, 1, 3, 0, 1, 3};
    bit any_done;

    bus.req = '0;
    bus.i2c_busy = 1'b0;
    bus.i2c_ack_error = 1'b0;
    for (int i = 0; i < 4; i++) bus.req_cmd[32*i +: 32] = cmds[i];

    do_reset();

    // single request, 2-cycle grant latency
    bus.req = 4'b0001;
    tick();
    check("t1_gnt_early", 32'(bus.gnt), 32'd0);
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_abusy", 32'(bus.arb_busy), 32'd1);
    bus.req = '0;
    do_xfer(0, 50, 1'b0, 2'b00);

    // round-robin with req held
    do_reset();
    bus.req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      wait_gnt(g);
      check("rr_gnt", 32'(g), 32'(1 << order[i]));
      if (i == 5) bus.req = '0;
      do_xfer(order[i], 3, 1'b0, 2'b00);
    end

    // NACK
    bus.req = 4'b0010;
    wait_gnt(g);
    check("nack_gnt", 32'(g), 32'h2);
    bus.req = '0;
    do_xfer(1, 4, 1'b1, 2'b01);

    // start timeout
    bus.req = 4'b0100;
    wait_gnt(g);
    check("st_gnt", 32'(g), 32'h4);
    bus.req = '0;
    tick();
    wait_done(n);
    check("st_cycles", 32'(n), 32'd16);
    check("st_done", 32'(bus.done), 32'h4);
    check("st_err", 32'(bus.err), 32'd1);
    check("st_code", 32'(bus.err_code), 32'h2);
    check("st_b17", 32'(bus.control_reg[17]), 32'd0);
    tick();
    check("st_code_hold", 32'(bus.err_code), 32'h2);
    check("st_done_clr", 32'(bus.done), 32'd0);

    // transfer timeout
    bus.req = 4'b1000;
    wait_gnt(g);
    check("xt_gnt", 32'(g), 32'h8);
    bus.req = '0;
    tick();
    bus.i2c_busy = 1'b1;
    tick();
    wait_done(n);
    check("xt_cycles", 32'(n), 32'd100);
    check("xt_done", 32'(bus.done), 32'h8);
    check("xt_code", 32'(bus.err_code), 32'h3);
    bus.i2c_busy = 1'b0;
    tick();

    // req dropped during GRANT: no grant
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick();
    check("drop_gnt", 32'(bus.gnt), 32'd0);
    check("drop_abusy", 32'(bus.arb_busy), 32'd0);
    tick();
    check("drop_gnt2", 32'(bus.gnt), 32'd0);

    // reset in RUN; pointer left at 1 would pick 2 next
    bus.req = 4'b0010;
    wait_gnt(g);
    check("rr1_gnt", 32'(g), 32'h2);
    bus.req = '0;
    tick();
    bus.i2c_busy = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_ctl", bus.control_reg, 32'd0);
    check("mid_rst_abusy", 32'(bus.arb_busy), 32'd0);
    reset = 1'b0;
    bus.i2c_busy = 1'b0;
    any_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done != 0) any_done = 1;
    end
    check("mid_rst_nodone", 32'(any_done), 32'd0);
    bus.req = 4'b0101;
    wait_gnt(g);
    check("post_rst_gnt", 32'(g), 32'h1);
    bus.req = '0;
    do_xfer(0, 2, 1'b0, 2'b00);
    bus.req = 4'b0100;
    wait_gnt(g);
    check("post_rst_gnt2", 32'(g), 32'h4);
    bus.req = '0;
    do_xfer(2, 2, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
